// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU console output path: UART FSM encoding,
// stdout store address and frame geometry.
package cpu_io_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uartState_e;

  // Memory-stage decode compares the store address against this.
  localparam logic [31:0] STDOUT_ADDR = 32'hFFFF_0000;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/sync_byte_fifo.sv
// Byte FIFO with registered count/full; head entry is presented combinationally.
// Push is ignored while full and pop is ignored while empty.
module sync_byte_fifo #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   nextCount;
  logic             doPush;
  logic             doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign empty  = (count == '0);
  assign dout   = mem[rdPtr];

  always_comb begin
    nextCount = count;
    if (doPush && !doPop) begin
      nextCount = count + 1'b1;
    end else if (!doPush && doPop) begin
      nextCount = count - 1'b1;
    end
  end

  // Pointers are exactly PTR_W bits, so they wrap at DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= nextCount;
      full  <= (nextCount == (PTR_W + 1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/stdout_uart_tx.sv
// Console output: buffers stdout store bytes and sends them as 8N1 frames,
// back-to-back with no idle gap while bytes are queued.
module stdout_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        full,
  output logic        busy,
  output logic        overflow,
  output logic        tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  uartState_e     state;
  logic [15:0]    baudCnt;
  logic [2:0]     bitIdx;
  logic [7:0]     shiftReg;
  logic           baudEnd;
  logic           fifoPop;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [7:0]     fifoDout;
  logic [PTR_W:0] fifoCount;
  logic           unusedUpperBits;

  // Only the low byte of the store is printable.
  assign unusedUpperBits = ^wr_data[31:8];

  assign baudEnd = (baudCnt == 16'(CLKS_PER_BIT - 1));

  // Pops are decided from the registered count, so a byte pushed into an
  // empty FIFO is only popped on the following edge.
  assign fifoPop = !fifoEmpty && ((state == IDLE) || (state == STOP && baudEnd));

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (fifoPop),
    .din   (wr_data[7:0]),
    .dout  (fifoDout),
    .count (fifoCount),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign full = fifoFull;
  assign busy = (state != IDLE) || (fifoCount != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en && fifoFull) begin
      overflow <= 1'b1;
    end
  end

  // tx is loaded with the level of the bit that starts on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifoEmpty) begin
            shiftReg <= fifoDout;
            baudCnt  <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baudEnd) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            tx      <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudEnd) begin
            baudCnt  <= '0;
            shiftReg <= {1'b0, shiftReg[7:1]};
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx     <= shiftReg[1];
              bitIdx <= bitIdx + 1'b1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudEnd) begin
            baudCnt <= '0;
            if (!fifoEmpty) begin
              shiftReg <= fifoDout;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed bench for stdout_uart_tx with a line monitor that decodes frames
// and a scoreboard of expected 10-bit frames.
module tb_stdout_uart_tx;
  import cpu_io_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        busy;
  logic        overflow;
  logic        tx;

  int total = 0;
  int bad   = 0;

  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];
  int         gap_q[$];

  stdout_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Line monitor: a frame starts at the first low sample; samples are taken
  // mid-bit. gap counts high samples seen since the previous frame's stop sample.
  initial begin : monitor
    logic [9:0] fr;
    int gap;
    gap = 100;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        fr[0] = tx;
        for (int i = 1; i < FRAME_BITS; i++) begin
          repeat (CPB) @(negedge clk);
          fr[i] = tx;
        end
        rx_q.push_back(fr);
        gap_q.push_back(gap);
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  function automatic logic [9:0] mk_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = ($urandom() & 32'hFFFF_FF00) | {24'h0, b};
  endtask

  task automatic release_wr();
    @(negedge clk);
    wr_en   = 1'b0;
    wr_data = $urandom();
  endtask

  // scoreboard drain: waits (bounded) for n frames and compares in order
  task automatic expect_frames(input int n, input string tag);
    int waited;
    logic [9:0] fr;
    logic [9:0] ex;
    int g;
    waited = 0;
    while (rx_q.size() < n && waited < n * FRAME_BITS * CPB + 100) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("%s_nframes", tag), rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (rx_q.size() == 0 || exp_q.size() == 0) break;
      fr = rx_q.pop_front();
      g  = gap_q.pop_front();
      ex = exp_q.pop_front();
      check($sformatf("%s_frame%0d", tag, i), fr, ex);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), g, 1);
    end
    exp_q.delete();
  endtask

  initial begin
    int cnt;
    int lowSeen;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;

    // reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
      check("idle_full", full, 0);
      check("idle_ovf", overflow, 0);
    end

    // single byte: latency, bit pattern, busy release
    strobe(8'h41);
    exp_q.push_back(mk_frame(8'h41));
    release_wr();
    check("lat_edge1_tx", tx, 1);
    check("lat_edge1_busy", busy, 1);
    @(negedge clk);
    check("lat_edge2_tx", tx, 0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("busy_drop_cycles", cnt, 40);
    expect_frames(1, "single");

    // four back-to-back bytes
    strobe(8'h01);
    strobe(8'h02);
    strobe(8'h03);
    strobe(8'h04);
    for (int b = 1; b <= 4; b++) exp_q.push_back(mk_frame(8'(b)));
    release_wr();
    check("four_full", full, 0);
    check("four_busy", busy, 1);
    expect_frames(4, "four");
    repeat (10) @(negedge clk);
    check("four_idle_busy", busy, 0);

    // six strobes: fifth fills the FIFO, sixth overflows
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        check("six_full_before", full, 1);
        check("six_ovf_before", overflow, 0);
      end
      wr_en   = 1'b1;
      wr_data = 32'h0000_0010 + 32'(i);
      if (i < 5) exp_q.push_back(mk_frame(8'(8'h10 + i)));
    end
    release_wr();
    check("six_ovf_after", overflow, 1);
    check("six_full_after", full, 1);
    expect_frames(5, "six");
    repeat (60) @(negedge clk);
    check("six_no_extra", rx_q.size(), 0);
    check("six_ovf_sticky", overflow, 1);

    // reset clears sticky overflow
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // push lands on the same edge the FSM pops with the FIFO full
    for (int i = 0; i <= 41; i++) begin
      @(negedge clk);
      if (i == 41) begin
        check("popfull_full_before", full, 1);
        check("popfull_ovf_before", overflow, 0);
      end
      wr_en   = (i < 5 || i == 41);
      wr_data = 32'h0000_0020 + 32'(i);
      if (i < 5) exp_q.push_back(mk_frame(8'(8'h20 + i)));
    end
    release_wr();
    check("popfull_ovf_after", overflow, 1);
    check("popfull_full_after", full, 0);
    expect_frames(5, "popfull");

    // push coincides with pop at count 1
    strobe(8'h77);
    strobe(8'h88);
    exp_q.push_back(mk_frame(8'h77));
    exp_q.push_back(mk_frame(8'h88));
    release_wr();
    check("cnt1_full", full, 0);
    check("cnt1_busy", busy, 1);
    expect_frames(2, "cnt1");

    // asynchronous reset in the middle of data bit 3 of 8'hA5
    repeat (10) @(negedge clk);
    strobe(8'hA5);
    release_wr();
    @(negedge clk);
    check("abort_start_tx", tx, 0);
    repeat (CPB * 4 + CPB / 2) @(negedge clk);
    check("abort_bit3_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    check("abort_tx_async", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_full", full, 0);
    check("abort_ovf", overflow, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lowSeen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lowSeen++;
    end
    check("abort_no_residual", lowSeen, 0);
    rx_q.delete();
    gap_q.delete();
    exp_q.delete();
    strobe(8'h5A);
    exp_q.push_back(mk_frame(8'h5A));
    release_wr();
    expect_frames(1, "post_abort");
    repeat (10) @(negedge clk);
    check("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stdout_uart_tx.md
Name: stdout_uart_tx

Overview:
- Console output unit downstream of the pipelined CPU's memory stage; consumes syscall print-character stores and serialises them onto an 8N1 UART line.
- The memory stage issues a one-cycle write strobe when MemWrite targets the stdout address; this block buffers bytes in a FIFO and asserts full so the hazard logic can stall fetch and decode.
- Pure consumer: no read-back data path to the CPU.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8, byte entries; power of two, 2..256.
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  single-cycle push strobe from the memory stage.
- wr_data  in  32  store data; only bits [7:0] are transmitted.
- full  out  1  FIFO full; the hazard unit stalls the stage on this signal.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- overflow  out  1  sticky; set when a push arrives while full.
- tx  out  1  UART line; idle high.

Behaviour:
- Reset, asynchronous and immediate even mid-frame: tx=1, full=0, busy=0, overflow=0, FIFO count=0, pointers=0, state=IDLE, bit and baud counters=0.
- Push: accepted on a clk edge when wr_en=1 and the registered count < FIFO_DEPTH. wr_data[7:0] is written at wr_ptr, and wr_ptr increments modulo FIFO_DEPTH.
- Push while full: the byte is dropped and overflow goes to 1 on that edge. overflow stays 1 until reset.
- Pop: only the FSM pops, and only when count > 0 at the edge. A push and a pop on the same edge leave count unchanged.
- Push into an empty FIFO is not popped on the same edge.
- full = (count == FIFO_DEPTH), registered.
- busy = (state != IDLE) or (count != 0).
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1; a bit ends when it reaches CLKS_PER_BIT-1.
- IDLE: tx=1. If count > 0, pop the head byte into an 8-bit shift register, clear the baud counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. LSB is sent first. After bit index 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end: if count > 0, pop and go directly to START (zero gap between frames); otherwise go to IDLE.
- Latency: wr_en sampled at edge n into an empty idle block gives count=1 after edge n. The FSM pops at edge n+1, and tx falls after edge n+1, i.e. 2 edges after the strobe.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- tx is driven from a register (no combinational glitches).
- Pointer wrap: both pointers wrap naturally at FIFO_DEPTH; count is PTR_W+1 bits wide.

Decomposition:
- Shared package cpu_io_pkg holds:
  - the FSM state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - the STDOUT_ADDR constant used by the memory-stage decode;
  - the UART frame bit count (10).
- One sub-module, sync_byte_fifo:
  - parameters: depth;
  - ports: push, pop, din, dout, count, full, empty;
  - reset: same asynchronous active-low reset;
  - dout is the head entry, available combinationally.
- The FSM, baud counter and shift register stay in stdout_uart_tx.

Test Plan (all with CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset then idle 50 cycles -> tx=1, busy=0, full=0, overflow=0 throughout.
- Single wr_en with wr_data=32'h0000_0041 -> tx low 2 edges after the strobe. Sampling mid-bit gives 0,1,0,0,0,0,0,1,0,1. busy drops 40 cycles after tx falls.
- Four consecutive strobes 8'h01,8'h02,8'h03,8'h04 -> full rises once the fourth push lands while the first byte is already popped, or stays at count ≤ 4. Four contiguous frames, 160 cycles, with no idle-high gap between the STOP and START bits. Decoded bytes arrive in order.
- Six strobes back-to-back with CLKS_PER_BIT=4 -> the first five are accepted (one popped, four buffered), the sixth sets overflow=1. Exactly five bytes are transmitted and overflow stays 1.
- Push on the same edge the FSM pops with count=FIFO_DEPTH -> push rejected, overflow=1, count decreases by 1. With count=1, the simultaneous push and pop leave count at 1.
- Assert rst_n=0 in the middle of the DATA bit 3 of byte 8'hA5 -> tx=1 immediately (asynchronous). After release, the FIFO is empty and no residual frame is sent. A new write of 8'h5A transmits cleanly.
